// File: rtl/keypad_scanner.sv
`timescale 1ns/1ps
// keypad_scanner: 3-column x 4-row matrix keypad scanner with frame-based
// debounce. Drives one column at a time, assembles a 12-bit frame of key
// bits (index row*3+col) and debounces whole frames into a one-hot key bus,
// a key code and a one-cycle press strobe.
// Optional auto-repeat of the press strobe is compiled in when the macro
// KEYPAD_REPEAT_EN is defined.
module keypad_scanner #(
    parameter int SCAN_DIV        = 25000,
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int REPEAT_DELAY    = 200,
    parameter int REPEAT_RATE     = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  key_row,
    output logic [2:0]  key_col,
    output logic [11:0] key_data,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_press
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_N    = CNT_W'(DEBOUNCE_FRAMES);

    // Reject parameter values the counters cannot represent sensibly.
    if (SCAN_DIV < 2 || DEBOUNCE_FRAMES < 2 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
        $error("keypad_scanner: illegal parameter value");
    end

    typedef enum logic [1:0] {S_IDLE, S_PRESS_WAIT, S_HELD} state_t;

    logic [DIV_W-1:0] div_q;
    logic [1:0]       col_q;
    logic [2:0]       col_oh_q;
    logic [11:0]      frame_q;
    logic [11:0]      frame_full;
    logic             sample;
    logic             frame_done;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       cand_q, cand_d;
    logic [11:0]      data_q, data_d;
    logic [3:0]       code_q, code_d;
    logic             valid_q, valid_d;
    logic             press_q, press_d;

    logic [1:0]       n_hits;
    logic [3:0]       hit_idx;
    logic             is_key;

    assign sample     = (div_q == DIV_LAST);
    assign frame_done = sample && (col_q == 2'd2);

    // Frame as it would look after this cycle's row sample: bits of the
    // current column come from the row lines, the rest from the frame register.
    for (genvar gi = 0; gi < 12; gi++) begin : g_frame_bit
        assign frame_full[gi] = (col_q == 2'(gi % 3)) ? key_row[gi / 3] : frame_q[gi];
    end

    // Scan divider, column rotation and frame accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q    <= '0;
            col_q    <= 2'd0;
            col_oh_q <= 3'b001;
            frame_q  <= '0;
        end else if (sample) begin
            div_q <= '0;
            if (col_q == 2'd2) begin
                col_q    <= 2'd0;
                col_oh_q <= 3'b001;
                frame_q  <= '0;
            end else begin
                col_q    <= col_q + 2'd1;
                col_oh_q <= {col_oh_q[1:0], 1'b0};
                frame_q  <= frame_full;
            end
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    // Classify the completed frame: none, exactly one key, or several.
    always_comb begin
        n_hits  = 2'd0;
        hit_idx = 4'd0;
        for (int i = 0; i < 12; i++) begin
            if (frame_full[i]) begin
                hit_idx = 4'(i);
                if (n_hits != 2'd2) n_hits = n_hits + 2'd1;
            end
        end
    end
    assign is_key = (n_hits == 2'd1);

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_armed_q, rep_armed_d;
`endif

    // Debounce state register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cand_q  <= 4'd0;
            data_q  <= '0;
            code_q  <= 4'd0;
            valid_q <= 1'b0;
            press_q <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_q   <= '0;
            rep_armed_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            data_q  <= data_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            press_q <= press_d;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_q   <= rep_cnt_d;
            rep_armed_q <= rep_armed_d;
`endif
        end
    end

    // Debounce next-state logic, evaluated once per completed frame.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        data_d  = data_q;
        code_d  = code_q;
        valid_d = valid_q;
        press_d = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_cnt_d   = rep_cnt_q;
        rep_armed_d = rep_armed_q;
`endif
        if (frame_done) begin
            case (state_q)
                S_IDLE: begin
                    if (is_key) begin
                        cand_d  = hit_idx;
                        cnt_d   = CNT_W'(1);
                        state_d = S_PRESS_WAIT;
                    end
                end
                S_PRESS_WAIT: begin
                    if (is_key && hit_idx == cand_q) begin
                        if (cnt_q + CNT_W'(1) == DEB_N) begin
                            state_d = S_HELD;
                            cnt_d   = '0;
                            data_d  = 12'd1 << cand_q;
                            code_d  = cand_q;
                            valid_d = 1'b1;
                            press_d = 1'b1;
`ifdef KEYPAD_REPEAT_EN
                            rep_cnt_d   = '0;
                            rep_armed_d = 1'b0;
`endif
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else if (is_key) begin
                        cand_d = hit_idx;
                        cnt_d  = CNT_W'(1);
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end
                end
                S_HELD: begin
                    if (frame_full[cand_q]) begin
                        cnt_d = '0;
`ifdef KEYPAD_REPEAT_EN
                        // First repeat after REPEAT_DELAY present frames,
                        // then one every REPEAT_RATE present frames.
                        if (rep_cnt_q + REP_W'(1) ==
                            (rep_armed_q ? REP_W'(REPEAT_RATE) : REP_W'(REPEAT_DELAY))) begin
                            press_d     = 1'b1;
                            rep_cnt_d   = '0;
                            rep_armed_d = 1'b1;
                        end else begin
                            rep_cnt_d = rep_cnt_q + REP_W'(1);
                        end
`endif
                    end else if (cnt_q + CNT_W'(1) == DEB_N) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        data_d  = '0;
                        code_d  = 4'd0;
                        valid_d = 1'b0;
`ifdef KEYPAD_REPEAT_EN
                        rep_cnt_d   = '0;
                        rep_armed_d = 1'b0;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign key_col   = col_oh_q;
    assign key_data  = data_q;
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_press = press_q;

endmodule

// File: tb/tb_keypad_scanner.sv
`timescale 1ns/1ps
// Bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_FRAMES=2 (12-cycle frame).
// A matrix model turns the pressed-key mask into row lines; each expected
// press strobe (cycle, key) is queued when stimulus is issued and a monitor
// compares it when the DUT strobes key_press.
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  key_row;
    logic [2:0]  key_col;
    logic [11:0] key_data;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_press;

    logic [11:0] pressed;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        int         at;
        logic [3:0] code;
    } exp_t;
    exp_t sb[$];

    keypad_scanner #(
        .SCAN_DIV(4),
        .DEBOUNCE_FRAMES(2),
        .REPEAT_DELAY(3),
        .REPEAT_RATE(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key_row(key_row),
        .key_col(key_col),
        .key_data(key_data),
        .key_code(key_code),
        .key_valid(key_valid),
        .key_press(key_press)
    );

    always #5 clk = ~clk;

    // Row r reads high when a pressed key in row r sits on the driven column.
    for (genvar gi = 0; gi < 4; gi++) begin : g_matrix
        assign key_row[gi] = |(pressed[gi*3 +: 3] & key_col);
    end

    // Cycle index since the last reset edge.
    always @(posedge clk) begin
        if (rst) cyc = 0;
        else     cyc = cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end else begin
            $display("ok   %s: cyc=%0d value=%0h", name, cyc, act);
        end
    endtask

    task automatic goto(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    task automatic expect_press(input int at, input logic [3:0] code);
        exp_t e;
        e.at   = at;
        e.code = code;
        sb.push_back(e);
    endtask

    // Monitor: every press strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && key_press) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL press_unexpected: cyc=%0d got code=%0d data=%03h expected no press",
                         cyc, key_code, key_data);
            end else begin
                exp_t e;
                logic [11:0] exp_data;
                e = sb.pop_front();
                exp_data = 12'd1 << e.code;
                if (cyc != e.at || key_code !== e.code || key_data !== exp_data || key_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL press: got cyc=%0d code=%0d data=%03h valid=%0b expected cyc=%0d code=%0d data=%03h valid=1",
                             cyc, key_code, key_data, key_valid, e.at, e.code, exp_data);
                end else begin
                    $display("ok   press: cyc=%0d code=%0d data=%03h", cyc, key_code, key_data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        pressed = '0;
        repeat (3) @(negedge clk);
        check("reset_col",   32'(key_col),   32'h1);
        check("reset_data",  32'(key_data),  32'h0);
        check("reset_code",  32'(key_code),  32'h0);
        check("reset_valid", 32'(key_valid), 32'h0);
        check("reset_press", 32'(key_press), 32'h0);
        rst = 1'b0;

        // Idle scan: column rotates every 4 cycles, nothing accepted.
        for (int k = 0; k < 60; k += 4) begin
            goto(k);
            check("scan_col", 32'(key_col), 32'(3'b001 << ((k / 4) % 3)));
        end
        goto(59);
        check("idle_valid", 32'(key_valid), 32'h0);

        // Key 7 held frames 5..8, accepted at end of frame 6, released after 2 empty frames.
        goto(60);
        pressed = 12'h080;
        expect_press(84, 4'd7);
        goto(83);
        check("k7_before", 32'(key_valid), 32'h0);
        goto(85);
        check("k7_data", 32'(key_data), 32'h080);
        check("k7_code", 32'(key_code), 32'h7);
        goto(108);
        pressed = '0;
        goto(131);
        check("k7_still", 32'(key_data), 32'h080);
        goto(132);
        check("k7_rel_data", 32'(key_data), 32'h0);
        check("k7_rel_code", 32'(key_code), 32'h0);

        // Key 4 bouncing: present in alternate frames only.
        for (int f = 12; f < 18; f++) begin
            goto(f * 12);
            pressed = (f % 2 == 0) ? 12'h010 : 12'h000;
        end
        goto(216);
        check("bounce_valid", 32'(key_valid), 32'h0);

        // Keys 0 and 11 together: multi-key frames never start a press.
        pressed = 12'h801;
        goto(252);
        check("multi_valid", 32'(key_valid), 32'h0);
        pressed = '0;

        // Key 0 held, key 11 added while held: key 0 remains accepted.
        goto(264);
        pressed = 12'h001;
        expect_press(288, 4'd0);
`ifdef KEYPAD_REPEAT_EN
        expect_press(324, 4'd0);
`endif
        goto(300);
        pressed = 12'h801;
        goto(330);
        check("hold_multi_data", 32'(key_data), 32'h001);
        goto(336);
        pressed = '0;
        goto(360);
        check("k0_rel_valid", 32'(key_valid), 32'h0);

        // Reset during the press-wait of key 3 discards the partial count.
        goto(372);
        pressed = 12'h008;
        goto(390);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_valid", 32'(key_valid), 32'h0);
        check("rst_mid_col",   32'(key_col),   32'h1);
        @(negedge clk);
        rst = 1'b0;
        expect_press(24, 4'd3);
        goto(23);
        check("k3_fresh", 32'(key_valid), 32'h0);
        goto(24);
        pressed = '0;
        goto(48);
        check("k3_rel_valid", 32'(key_valid), 32'h0);

        // Key 5 held 10 frames (auto-repeat strobes only when compiled in).
        goto(60);
        pressed = 12'h020;
        expect_press(84, 4'd5);
`ifdef KEYPAD_REPEAT_EN
        expect_press(120, 4'd5);
        expect_press(144, 4'd5);
        expect_press(168, 4'd5);
`endif
        goto(180);
        pressed = '0;
        goto(203);
        check("k5_still", 32'(key_data), 32'h020);
        goto(204);
        check("k5_rel_valid", 32'(key_valid), 32'h0);
        check("k5_rel_code",  32'(key_code),  32'h0);

        goto(216);
        check("sb_drained", 32'(sb.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
